// File: rtl/bus_if_split_pkg.sv
// Bus package and splitter helper package.
//   Bus              : bus widths, command/response encodings, split target codes.
//   bus_if_split_pkg : order-queue entry width and address-match helper.
package Bus;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] { IDLE = 2'd0, WR = 2'd1, RD = 2'd2 } Cmd;
  typedef enum logic [1:0] { NULL = 2'd0, DVA = 2'd1, ERR = 2'd3 } Resp;

  typedef enum logic [1:0] { T_OUT0, T_OUT1, T_LOCAL } Split_target;
endpackage

package bus_if_split_pkg;
  import Bus::*;

  localparam int TGT_W = 2;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (a & mask) == base;
  endfunction
endpackage

// File: rtl/bus_if.sv
// Bus_if: single-channel command/response bus.
//   master drives MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept
//   slave  drives SCmdAccept, SResp, SData
interface Bus_if;
  import Bus::*;
  logic              MReset_n;
  Cmd                MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MData;
  logic [BE_W-1:0]   MByteEn;
  logic              MRespAccept;
  logic              SCmdAccept;
  Resp               SResp;
  logic [DATA_W-1:0] SData;

  modport master (output MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
                  input  SCmdAccept, SResp, SData);
  modport slave  (input  MReset_n, MCmd, MAddr, MData, MByteEn, MRespAccept,
                  output SCmdAccept, SResp, SData);
endinterface

// File: rtl/bus_if_split_order_fifo.sv
// In-flight order queue: synchronous FIFO, show-ahead head, sync active-high reset.
//   i_clk, i_rst      : clock, reset
//   i_push, i_data    : enqueue (ignored when full)
//   i_pop             : dequeue (ignored when empty); push+pop in one cycle allowed
//   o_head            : entry at head, valid when !o_empty
//   o_empty, o_full, o_count : occupancy
module bus_if_split_order_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/bus_if_split.sv
// bus_if_split: routes one Bus_if master to two Bus_if slaves by address and
// returns responses in issue order via an in-flight order queue.
//   Clk, Reset : clock, synchronous active-high reset
//   in         : upstream master (Bus_if.slave)
//   out_0/1    : slave regions (Bus_if.master); out_1 decode has priority
// Optional: define BUS_IF_SPLIT_DECERR_EN to answer unmapped commands locally
// with ERR; otherwise unmapped addresses go to out_0.
module bus_if_split
  import Bus::*;
  import bus_if_split_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_0        = '0,
  parameter logic [ADDR_W-1:0] MASK_0        = '0,
  parameter logic [ADDR_W-1:0] BASE_1        = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MASK_1        = 32'h8000_0000,
  parameter int                NUM_IN_FLIGHT = 4
) (
  input  logic  Clk,
  input  logic  Reset,
  Bus_if.slave  in,
  Bus_if.master out_0,
  Bus_if.master out_1
);
  localparam int CW = $clog2(NUM_IN_FLIGHT + 1);

  Split_target       w_tgt, w_head;
  logic [TGT_W-1:0]  w_head_raw;
  logic              w_active, w_hit0, w_hit1, w_sel_acc, w_issue;
  logic              w_push, w_pop, w_empty, w_full, w_rsp_live;
  logic              w_unused_fifo_full, w_unused_mreset_n;
  logic [CW-1:0]     w_count;
  Resp               w_head_resp;
  logic [DATA_W-1:0] w_head_data;

  assign w_unused_mreset_n = in.MReset_n;
  assign out_0.MReset_n    = !Reset;
  assign out_1.MReset_n    = !Reset;

  // ---------------- decode ----------------
  assign w_active = (in.MCmd != IDLE);
  assign w_hit1   = addr_hit(in.MAddr, BASE_1, MASK_1);
  assign w_hit0   = addr_hit(in.MAddr, BASE_0, MASK_0);

  always_comb begin
    w_tgt = T_OUT0;
    if (w_hit1)      w_tgt = T_OUT1;
    else if (w_hit0) w_tgt = T_OUT0;
`ifdef BUS_IF_SPLIT_DECERR_EN
    else             w_tgt = T_LOCAL;
`endif
  end

  always_comb begin
    w_sel_acc = 1'b0;
    case (w_tgt)
      T_OUT0:  w_sel_acc = out_0.SCmdAccept;
      T_OUT1:  w_sel_acc = out_1.SCmdAccept;
`ifdef BUS_IF_SPLIT_DECERR_EN
      T_LOCAL: w_sel_acc = 1'b1;
`endif
      default: w_sel_acc = 1'b0;
    endcase
  end

  // ---------------- request path ----------------
  // full comes from the registered count, so a same-cycle pop never frees a slot.
  assign w_full         = (w_count == CW'(NUM_IN_FLIGHT));
  assign w_issue        = !Reset && w_active && !w_full;
  assign w_push         = w_issue && w_sel_acc;
  assign in.SCmdAccept  = w_push;

  always_comb begin
    out_0.MCmd    = IDLE;
    out_0.MAddr   = '0;
    out_0.MData   = '0;
    out_0.MByteEn = '0;
    out_1.MCmd    = IDLE;
    out_1.MAddr   = '0;
    out_1.MData   = '0;
    out_1.MByteEn = '0;
    if (w_issue && w_tgt == T_OUT0) begin
      out_0.MCmd    = in.MCmd;
      out_0.MAddr   = in.MAddr;
      out_0.MData   = in.MData;
      out_0.MByteEn = in.MByteEn;
    end
    if (w_issue && w_tgt == T_OUT1) begin
      out_1.MCmd    = in.MCmd;
      out_1.MAddr   = in.MAddr;
      out_1.MData   = in.MData;
      out_1.MByteEn = in.MByteEn;
    end
  end

  // ---------------- order queue ----------------
  bus_if_split_order_fifo #(
    .W     (TGT_W),
    .DEPTH (NUM_IN_FLIGHT)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_data  (w_tgt),
    .i_pop   (w_pop),
    .o_head  (w_head_raw),
    .o_empty (w_empty),
    .o_full  (w_unused_fifo_full),
    .o_count (w_count)
  );

  assign w_head = Split_target'(w_head_raw);

  // ---------------- response path ----------------
  // Only the head slave may hand a response up; the other one is stalled by
  // MRespAccept=0 until its entry reaches the head.
  assign w_rsp_live = !Reset && !w_empty;

  always_comb begin
    w_head_resp = NULL;
    w_head_data = '0;
    if (w_rsp_live) begin
      case (w_head)
        T_OUT0: begin
          w_head_resp = out_0.SResp;
          w_head_data = out_0.SData;
        end
        T_OUT1: begin
          w_head_resp = out_1.SResp;
          w_head_data = out_1.SData;
        end
`ifdef BUS_IF_SPLIT_DECERR_EN
        T_LOCAL: w_head_resp = ERR;
`endif
        default: ;
      endcase
    end
  end

  assign in.SResp          = w_head_resp;
  assign in.SData          = w_head_data;
  assign out_0.MRespAccept = w_rsp_live && (w_head == T_OUT0) && in.MRespAccept;
  assign out_1.MRespAccept = w_rsp_live && (w_head == T_OUT1) && in.MRespAccept;
  assign w_pop             = w_rsp_live && in.MRespAccept && (w_head_resp != NULL);
endmodule
